// File: rtl/bitwise_alu_arbiter.sv
// Two-requester arbiter in front of a single-op bitwise ALU (IDLE -> EXEC -> RESP).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to requester 0.
module bitwise_alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    input  logic             rsp_ready0,
    input  logic             rsp_ready1,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             win_q, win_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             grant;
    logic             grant_id;

    function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    // last_q holds the most recent winner; reset to 1 so requester 0 wins the first contention.
    logic last_q;

    always_comb begin
        grant_id = 1'b0;
        if (req0 && req1) grant_id = ~last_q;
        else              grant_id = ~req0;
    end

    always_ff @(posedge clk) begin
        if (rst)        last_q <= 1'b1;
        else if (grant) last_q <= grant_id;
    end
`else
    assign grant_id = ~req0;
`endif

    // Grant is combinational in IDLE so operands are captured in the same cycle gnt is seen.
    assign grant = (state_q == IDLE) && (req0 || req1) && !rst;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    win_d   = grant_id;
                    op_d    = grant_id ? op1 : op0;
                    a_d     = grant_id ? a1 : a0;
                    b_d     = grant_id ? b1 : b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = alu(op_q, a_q, b_q);
                state_d = RESP;
            end
            RESP: begin
                if (win_q ? rsp_ready1 : rsp_ready0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            op_q    <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
        end
    end

    assign gnt0       = grant && !grant_id;
    assign gnt1       = grant && grant_id;
    assign rsp_valid0 = (state_q == RESP) && !win_q;
    assign rsp_valid1 = (state_q == RESP) && win_q;
    assign rsp_data   = data_q;
    assign busy       = (state_q != IDLE);

endmodule
